branch_fetch_unit: RTL

Consumer side of the condition-unit jump protocol. It takes the registered jump decision (`JmpSel`) and branch target, owns the program counter, and drives the fetch address. On a taken jump it redirects the PC and flushes the younger in-flight pipeline stages for a fixed number of advancing cycles. It sits between the condition unit and the instruction memory / fetch-decode pipeline registers.

---
 rtl/branch_fetch_unit.sv | 109 ++++++++++
 1 files changed

// File: rtl/branch_fetch_unit.sv
// Program counter owner and fetch redirect on the consumer side of the jump protocol.
// Optional feature: define BRANCH_COUNTER_EN to build the saturating taken-jump counter.
module branch_fetch_unit #(
   parameter int                ADDR_W       = 32,
   parameter int                FLUSH_STAGES = 2,
   parameter logic [ADDR_W-1:0] RESET_PC     = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              JmpSel,
   input  logic [ADDR_W-1:0] JmpTarget,
   input  logic              halt,
   output logic [ADDR_W-1:0] pc,
   output logic              flush,
   output logic              halted,
   output logic              misalign,
   output logic [15:0]       taken_cnt
);

   typedef enum logic [1:0] {RUN, FLUSH, HALTED} state_t;

   localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_STAGES);

   state_t     state;
   logic [3:0] flush_left;
   logic       jump_taken;

   function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
      return {addr[ADDR_W-1:2], 2'b00};
   endfunction

   // Wraps modulo 2^ADDR_W by construction of the result width.
   function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] addr);
      return addr + ADDR_W'(4);
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] value);
      return (value == 16'hFFFF) ? value : value + 16'd1;
   endfunction

   // A resolved jump is taken in RUN regardless of stall so it is never lost.
   assign jump_taken = (state == RUN) && JmpSel;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= RUN;
         pc         <= RESET_PC;
         flush      <= 1'b0;
         halted     <= 1'b0;
         misalign   <= 1'b0;
         flush_left <= 4'd0;
      end else begin
         misalign <= 1'b0;
         case (state)
            RUN: begin
               if (JmpSel) begin
                  pc         <= word_align(JmpTarget);
                  flush_left <= FLUSH_INIT;
                  flush      <= 1'b1;
                  misalign   <= |JmpTarget[1:0];
                  state      <= FLUSH;
               end else if (halt && !stall) begin
                  halted <= 1'b1;
                  state  <= HALTED;
               end else if (!stall) begin
                  pc <= pc_inc(pc);
               end
            end
            // Jump and halt requests here come from squashed instructions.
            FLUSH: begin
               if (!stall) begin
                  pc         <= pc_inc(pc);
                  flush_left <= flush_left - 4'd1;
                  if (flush_left == 4'd1) begin
                     flush <= 1'b0;
                     state <= RUN;
                  end
               end
            end
            HALTED: begin
               halted <= 1'b1;
            end
            default: begin
               state  <= RUN;
               flush  <= 1'b0;
               halted <= 1'b0;
            end
         endcase
      end
   end

`ifdef BRANCH_COUNTER_EN
   logic [15:0] taken_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         taken_q <= 16'd0;
      end else if (jump_taken) begin
         taken_q <= sat_inc16(taken_q);
      end
   end

   assign taken_cnt = taken_q;
`else
   assign taken_cnt = 16'd0;
`endif

endmodule
